// File: rtl/burst_cache_ctrl_if.sv
// Bus bundle for burst_cache_ctrl: CPU request port, SDRAM burst port and
// cache control/status. The optional statistics outputs exist only when
// CACHE_STATS_EN is defined.
interface burst_cache_ctrl_if #(
    parameter int unsigned SDRAMWIDTH = 16
) ();
    logic [31:0]           cpu_addr;
    logic                  cpu_req;
    logic                  cpu_wr;
    logic [3:0]            bytesel;
    logic [31:0]           data_from_cpu;
    logic [31:0]           data_to_cpu;
    logic                  cpu_valid;
    logic [SDRAMWIDTH-1:0] data_from_sdram;
    logic [31:0]           sdram_addr;
    logic                  sdram_req;
    logic                  sdram_fill;
    logic                  ready;
    logic                  busy;
    logic                  flush;
    logic                  flush_done;
`ifdef CACHE_STATS_EN
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;
`endif

    // Environment side: CPU and SDRAM controller.
    modport master (
        output cpu_addr, cpu_req, cpu_wr, bytesel, data_from_cpu, data_from_sdram,
        output sdram_fill, flush,
        input  data_to_cpu, cpu_valid, sdram_addr, sdram_req, ready, busy, flush_done
`ifdef CACHE_STATS_EN
        , input hit_count, miss_count
`endif
    );

    // Cache controller side.
    modport slave (
        input  cpu_addr, cpu_req, cpu_wr, bytesel, data_from_cpu, data_from_sdram,
        input  sdram_fill, flush,
        output data_to_cpu, cpu_valid, sdram_addr, sdram_req, ready, busy, flush_done
`ifdef CACHE_STATS_EN
        , output hit_count, miss_count
`endif
    );
endinterface

// File: rtl/burst_cache_ctrl.sv
// Direct-mapped read cache between CPU and SDRAM burst port. Line fills are
// critical word first with wrap-around; CPU writes are snooped and merged
// into hit lines. Optional hit/miss counters are enabled by CACHE_STATS_EN.
module burst_cache_ctrl #(
    parameter int unsigned CACHEBITS  = 11,
    parameter int unsigned LINEBITS   = 2,
    parameter int unsigned SDRAMWIDTH = 16
) (
    input logic            clk,
    input logic            reset,
    burst_cache_ctrl_if.slave bus
);
    localparam int unsigned BEATS     = 32 / SDRAMWIDTH;
    localparam int unsigned INDEXBITS = CACHEBITS - LINEBITS;
    localparam int unsigned TAGBITS   = 30 - CACHEBITS;

    typedef enum logic [2:0] {StInit, StFlush, StIdle, StLookup, StFill, StWrUpd, StHold} state_e;

    logic [TAGBITS:0]     r_tag_ram  [0:(1 << INDEXBITS) - 1];
    logic [31:0]          r_data_ram [0:(1 << CACHEBITS) - 1];

    state_e               r_state;
    logic [31:0]          r_addr, r_wdata, r_data_q, r_dout;
    logic [3:0]           r_bsel;
    logic                 r_wr, r_valid, r_sdram_req, r_ready, r_flush_done, r_flush_pend;
    logic                 r_filling, r_beat, r_done;
    logic [TAGBITS:0]     r_tag_q;
    logic [INDEXBITS-1:0] r_fidx;
    logic [LINEBITS-1:0]  r_woff, r_wcnt;
    logic [15:0]          r_hi;

    logic [INDEXBITS-1:0] w_index, w_in_index;
    logic [CACHEBITS-1:0] w_in_daddr;
    logic                 w_hit, w_accept, w_beat_valid, w_beat_last, w_word_done, w_fill_last;
    logic [31:0]          w_word, w_merged;
    logic                 w_tag_we, w_data_we;
    logic [INDEXBITS-1:0] w_tag_waddr;
    logic [TAGBITS:0]     w_tag_wdata;
    logic [CACHEBITS-1:0] w_data_waddr;
    logic [31:0]          w_data_wdata;

    assign w_index      = r_addr[CACHEBITS+1:LINEBITS+2];
    assign w_in_index   = bus.cpu_addr[CACHEBITS+1:LINEBITS+2];
    assign w_in_daddr   = bus.cpu_addr[CACHEBITS+1:2];
    assign w_hit        = r_tag_q[TAGBITS] && (r_tag_q[TAGBITS-1:0] == r_addr[31:CACHEBITS+2]);
    // A pending or simultaneous flush wins over a new CPU request.
    assign w_accept     = (r_state == StIdle) && !(r_flush_pend || bus.flush) &&
                          bus.cpu_req && !r_valid;
    assign w_beat_valid = (r_state == StFill) && (r_filling || bus.sdram_fill);
    assign w_beat_last  = (BEATS == 1) ? 1'b1 : r_beat;
    assign w_word_done  = w_beat_valid && w_beat_last;
    assign w_fill_last  = w_word_done && (r_wcnt == '1);

    // Narrow SDRAM: first beat of a word is the most significant half.
    if (SDRAMWIDTH == 16) begin : g_sd16
        assign w_word = {r_hi, bus.data_from_sdram};
    end else begin : g_sd32
        assign w_word = bus.data_from_sdram[31:0];
    end

    // Byte-lane merge of snooped write data over the stored word.
    always_comb begin
        w_merged = r_data_q;
        for (int b = 0; b < 4; b++) begin
            if (r_bsel[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
        end
    end

    // RAM write port selection: flush sweep / miss tag allocate, fill words / snoop merge.
    always_comb begin
        w_tag_we     = 1'b0;
        w_tag_waddr  = w_index;
        w_tag_wdata  = {1'b1, r_addr[31:CACHEBITS+2]};
        w_data_we    = 1'b0;
        w_data_waddr = {w_index, r_woff};
        w_data_wdata = w_word;
        if (r_state == StFlush) begin
            w_tag_we    = 1'b1;
            w_tag_waddr = r_fidx;
            w_tag_wdata = '0;
        end else if ((r_state == StLookup) && !r_wr && !w_hit) begin
            w_tag_we = 1'b1;
        end
        if (w_word_done) begin
            w_data_we = 1'b1;
        end else if ((r_state == StWrUpd) && w_hit && !r_addr[30]) begin
            // Bit 30 selects the uncached image, which must not touch cached data.
            w_data_we    = 1'b1;
            w_data_waddr = r_addr[CACHEBITS+1:2];
            w_data_wdata = w_merged;
        end
    end

    // Tag and data RAMs: synchronous write, read captured when a request is accepted.
    always_ff @(posedge clk) begin
        if (w_tag_we)  r_tag_ram[w_tag_waddr]   <= w_tag_wdata;
        if (w_data_we) r_data_ram[w_data_waddr] <= w_data_wdata;
        if (w_accept) begin
            r_tag_q  <= r_tag_ram[w_in_index];
            r_data_q <= r_data_ram[w_in_daddr];
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StInit;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_bsel       <= '0;
            r_wr         <= 1'b0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_sdram_req  <= 1'b0;
            r_ready      <= 1'b0;
            r_flush_done <= 1'b0;
            r_flush_pend <= 1'b0;
            r_fidx       <= '0;
            r_filling    <= 1'b0;
            r_beat       <= 1'b0;
            r_done       <= 1'b0;
            r_woff       <= '0;
            r_wcnt       <= '0;
            r_hi         <= '0;
        end else begin
            r_flush_done <= 1'b0;
            if (bus.flush) r_flush_pend <= 1'b1;
            unique case (r_state)
                StInit: begin
                    r_fidx  <= '0;
                    r_state <= StFlush;
                end
                StFlush: begin
                    r_fidx <= r_fidx + 1'b1;
                    if (r_fidx == '1) begin
                        r_state      <= StIdle;
                        r_ready      <= 1'b1;
                        r_flush_done <= 1'b1;
                    end
                end
                StIdle: begin
                    if (r_flush_pend || bus.flush) begin
                        r_flush_pend <= 1'b0;
                        r_fidx       <= '0;
                        r_state      <= StFlush;
                    end else if (w_accept) begin
                        r_addr  <= bus.cpu_addr;
                        r_wr    <= bus.cpu_wr;
                        r_bsel  <= bus.bytesel;
                        r_wdata <= bus.data_from_cpu;
                        r_state <= StLookup;
                    end
                end
                StLookup: begin
                    if (r_wr) begin
                        r_state <= StWrUpd;
                    end else if (w_hit) begin
                        r_valid <= 1'b1;
                        r_dout  <= r_data_q;
                        r_state <= StHold;
                    end else begin
                        r_sdram_req <= 1'b1;
                        r_filling   <= 1'b0;
                        r_beat      <= 1'b0;
                        r_done      <= 1'b0;
                        r_woff      <= r_addr[LINEBITS+1:2];
                        r_wcnt      <= '0;
                        r_state     <= StFill;
                    end
                end
                StFill: begin
                    if (bus.sdram_fill) begin
                        r_sdram_req <= 1'b0;
                        r_filling   <= 1'b1;
                    end
                    if (w_beat_valid) begin
                        r_beat <= ~r_beat;
                        r_hi   <= bus.data_from_sdram[15:0];
                    end
                    // CPU may take the critical word and drop its request mid-fill.
                    if (r_valid && !bus.cpu_req) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    if (w_word_done) begin
                        r_woff <= r_woff + 1'b1;
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == '0) begin
                            r_dout  <= w_word;
                            r_valid <= 1'b1;
                        end
                        if (w_fill_last) begin
                            r_filling <= 1'b0;
                            if (!bus.cpu_req || r_done) begin
                                r_valid <= 1'b0;
                                r_state <= StIdle;
                            end else begin
                                r_state <= StHold;
                            end
                        end
                    end
                end
                StWrUpd: begin
                    r_state <= StHold;
                end
                StHold: begin
                    if (!bus.cpu_req) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Read-lookup hit/miss counters, cleared by reset and by a flush request.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == StLookup) && !r_wr) begin
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 1'b1;
            else       r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;
`endif

    assign bus.data_to_cpu = r_dout;
    assign bus.cpu_valid   = r_valid;
    assign bus.sdram_addr  = r_addr;
    assign bus.sdram_req   = r_sdram_req;
    assign bus.ready       = r_ready;
    assign bus.busy        = (r_state != StIdle);
    assign bus.flush_done  = r_flush_done;
endmodule

// File: tb/tb_burst_cache_ctrl.sv
// Self-checking bench for burst_cache_ctrl with default parameters
// (2048 words, 4-word lines, 16-bit SDRAM). A behavioural SDRAM model
// answers line-fill requests critical word first.
module tb_burst_cache_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   n_bursts;
    bit   sdram_auto;

    burst_cache_ctrl_if #(.SDRAMWIDTH(16)) bus ();

    burst_cache_ctrl #(
        .CACHEBITS (11),
        .LINEBITS  (2),
        .SDRAMWIDTH(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        hit;
    } rd_vec_t;

    rd_vec_t vecs [6];

    // SDRAM contents: line 0x100 holds 0x11112222, 0x33334444, 0x55556666, 0x77778888.
    function automatic logic [31:0] sdram_word(input logic [31:0] a);
        logic [15:0] k, hi, lo;
        k  = {14'd0, a[3:2]};
        hi = 16'h1111 * (16'd2 * k + 16'd1);
        lo = 16'h1111 * (16'd2 * k + 16'd2);
        return {hi, lo} ^ {a[27:12], a[27:12]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 1100) begin
            tick();
            n++;
        end
        check("init_len", n, 513);
        check("init_flush_done_hi", bus.flush_done, 1);
        tick();
        check("init_flush_done_lo", bus.flush_done, 0);
        check("init_idle", bus.busy, 0);
    endtask

    // Request already presented; DUT accepts on the next edge.
    task automatic read_tail(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
        int b0, n;
        b0 = n_bursts;
        tick();
        tick();
        check("valid_1clk", bus.cpu_valid, {31'd0, exp_hit});
        check("sdram_req", bus.sdram_req, {31'd0, !exp_hit});
        if (!exp_hit) begin
            check("sdram_addr", bus.sdram_addr, a);
            n = 0;
            while (!bus.cpu_valid && n < 50) begin
                tick();
                n++;
            end
            check("miss_lat", n, 4);
        end
        check("rd_data", bus.data_to_cpu, exp);
        bus.cpu_req = 1'b0;
        tick();
        check("valid_fall", bus.cpu_valid, 0);
        n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        check("back_idle", bus.busy, 0);
        check("bursts", n_bursts - b0, exp_hit ? 0 : 1);
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
        bus.cpu_addr = a;
        bus.cpu_wr   = 1'b0;
        bus.cpu_req  = 1'b1;
        read_tail(a, exp, exp_hit);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.cpu_addr      = a;
        bus.cpu_wr        = 1'b1;
        bus.bytesel       = be;
        bus.data_from_cpu = d;
        bus.cpu_req       = 1'b1;
        tick();
        tick();
        tick();
        check("wr_no_valid", bus.cpu_valid, 0);
        bus.cpu_req = 1'b0;
        bus.cpu_wr  = 1'b0;
        tick();
        check("wr_idle", bus.busy, 0);
    endtask

    // SDRAM burst model: two idle cycles, then 8 contiguous beats, MS half first.
    initial begin
        logic [31:0] req_a;
        logic [31:0] w;
        bus.sdram_fill      = 1'b0;
        bus.data_from_sdram = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sdram_auto && bus.sdram_req && !reset) begin
                req_a = bus.sdram_addr;
                n_bursts++;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                for (int i = 0; i < 8; i++) begin
                    w = sdram_word({req_a[31:4], req_a[3:2] + 2'(i / 2), 2'b00});
                    bus.sdram_fill      = (i == 0);
                    bus.data_from_sdram = (i % 2 == 0) ? w[31:16] : w[15:0];
                    @(posedge clk);
                    #1;
                end
                bus.sdram_fill = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n_chk    = 0;
        n_err    = 0;
        n_bursts = 0;
        sdram_auto = 1'b1;
        vecs[0] = '{addr: 32'h0000_0100, data: 32'h1111_2222, hit: 1'b0};
        vecs[1] = '{addr: 32'h0000_0100, data: 32'h1111_2222, hit: 1'b1};
        vecs[2] = '{addr: 32'h0000_0100, data: 32'h1111_2222, hit: 1'b1};
        vecs[3] = '{addr: 32'h0000_0104, data: 32'h3333_4444, hit: 1'b1};
        vecs[4] = '{addr: 32'h0000_0108, data: 32'h5555_6666, hit: 1'b1};
        vecs[5] = '{addr: 32'h0000_010C, data: 32'h7777_8888, hit: 1'b1};

        reset             = 1'b1;
        bus.cpu_addr      = '0;
        bus.cpu_req       = 1'b0;
        bus.cpu_wr        = 1'b0;
        bus.bytesel       = '0;
        bus.data_from_cpu = '0;
        bus.flush         = 1'b0;
        tick();
        tick();
        tick();
        check("rst_ready", bus.ready, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_valid", bus.cpu_valid, 0);
        check("rst_sdram_req", bus.sdram_req, 0);
        check("rst_flush_done", bus.flush_done, 0);
        check("rst_data", bus.data_to_cpu, 0);
        reset = 1'b0;
        wait_ready();

        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                // Flush and read together: flush first, then the read misses at 0x10C.
                bus.cpu_addr = 32'h0000_010C;
                bus.cpu_wr   = 1'b0;
                bus.cpu_req  = 1'b1;
                bus.flush    = 1'b1;
                tick();
                bus.flush = 1'b0;
                check("flush_busy", bus.busy, 1);
                n = 0;
                while (!bus.flush_done && n < 600) begin
                    tick();
                    n++;
                end
                check("flush_len", n, 512);
                check("flush_done", bus.flush_done, 1);
                check("flush_no_valid", bus.cpu_valid, 0);
                read_tail(32'h0000_010C, 32'h7777_8888, 1'b0);
            end
            cpu_read(vecs[i].addr, vecs[i].data, vecs[i].hit);
        end

        // Snoop merges: low half of 0x104, high half of 0x108.
        cpu_write(32'h0000_0104, 4'b0011, 32'hAABB_CCDD);
        cpu_read(32'h0000_0104, 32'h3333_CCDD, 1'b1);
        cpu_write(32'h0000_0108, 4'b1100, 32'h1234_5678);
        cpu_read(32'h0000_0108, 32'h1234_6666, 1'b1);
        // Uncached image never updates, even when its line is resident.
        cpu_write(32'h4000_0104, 4'b1111, 32'hDEAD_BEEF);
        cpu_read(32'h0000_0104, 32'h3333_CCDD, 1'b1);
        cpu_read(32'h4000_0104, 32'h3333_4444, 1'b0);
        cpu_write(32'h4000_0104, 4'b1111, 32'hDEAD_BEEF);
        cpu_read(32'h4000_0104, 32'h3333_4444, 1'b1);

        // Reset while a fill is outstanding.
        sdram_auto   = 1'b0;
        bus.cpu_addr = 32'h0000_2100;
        bus.cpu_wr   = 1'b0;
        bus.cpu_req  = 1'b1;
        tick();
        tick();
        check("mf_sdram_req", bus.sdram_req, 1);
        tick();
        tick();
        check("mf_busy", bus.busy, 1);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        check("mf_req_drop", bus.sdram_req, 0);
        check("mf_ready", bus.ready, 0);
        check("mf_valid", bus.cpu_valid, 0);
        check("mf_data", bus.data_to_cpu, 0);
        tick();
        reset      = 1'b0;
        sdram_auto = 1'b1;
        wait_ready();
        cpu_read(32'h0000_2100, sdram_word(32'h0000_2100), 1'b0);
        cpu_read(32'h0000_2104, sdram_word(32'h0000_2104), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
